multicycle_controller: RTL
==========================

# multicycle_controller

Multicycle control unit for the 3-bit-opcode core. It sequences a shared datapath: one ALU, one instruction/data memory, and the IR/OldPC/ALUOut/Data registers. It replaces single-cycle decoding with a Moore FSM that issues per-state mux selects and write strobes, and it stalls on a memory ready handshake. It sits between the instruction register (Op, funct3), the ALU Zero flag, the memory port and all datapath enables.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Op` in 3: opcode from the IR.
- `funct3` in 2: IR funct bits; `00` with Op `001` means ld.
- `Zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the access this cycle.
- `MemReq` out 1: memory access request.
- `MemWrite` out 1: store.
- `AdrSrc` out 1: 0 = PC, 1 = ALUOut.
- `IRWrite` out 1: latch the instruction and OldPC.
- `PCWrite` out 1: PC load.
- `RegWrite` out 1: register file write.
- `ResultSrc` out 2: 00 = ALUOut, 01 = Data, 10 = ALU result.
- `ALUSrcA` out 2: 00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB` out 2: 00 = rs2, 01 = imm, 10 = constant 4.
- `ALUOp` out 2: 00 = add, 01 = subtract/compare, 10 = funct-decoded.
- `ImmSrc` out 2: 00 R/jr, 01 I, 10 S/B, 11 jal.
- `retire` out 1: one-cycle pulse on instruction completion.
- `instret` out CNT_W: retired-instruction count.

## Operation
- **Output rule.** Outputs are combinational from state (plus Op/funct3/Zero/mem_ready where noted). Every unlisted strobe is 0 and every unlisted select is 00. ImmSrc is always decoded from Op.
- **IDLE.** All outputs 0. Next state is FETCH.
- **FETCH.**
  - MemReq=1.
  - When mem_ready=1: IRWrite=1, PCWrite=1, ResultSrc=10, ALUSrcB=10 (PC+4). Next state is DECODE.
  - Otherwise stay in FETCH.
- **DECODE.** ALUSrcA=01, ALUSrcB=01, giving target into ALUOut. Next state by Op:
  - `000` → EXEC_R
  - `001` with funct3=00 → MEM_ADDR; `001` otherwise → EXEC_I
  - `010` → EXEC_I
  - `011` → MEM_ADDR
  - `100`/`101` → BRANCH
  - `110` → JAL
  - `111` → JR
- **EXEC_R.** A=10, B=00, ALUOp=10. Next state is ALU_WB.
- **EXEC_I.** A=10, B=01, ALUOp=10. Next state is ALU_WB.
- **ALU_WB.** RegWrite=1, ResultSrc=00, retire. Next state is FETCH.
- **MEM_ADDR.** A=10, B=01. Next state is MEM_RD for ld, MEM_WR for st.
- **MEM_RD.** MemReq=1, AdrSrc=1. Wait for mem_ready, then go to MEM_WB.
- **MEM_WB.** RegWrite=1, ResultSrc=01, retire. Next state is FETCH.
- **MEM_WR.** MemReq=1, MemWrite=1, AdrSrc=1. Wait for mem_ready; on ready, retire and go to FETCH.
- **BRANCH.**
  - Drives A=10, B=00, ALUOp=01, ResultSrc=00, retire.
  - PCWrite = (Op=100 & Zero) | (Op=101 & !Zero).
  - Next state is FETCH.
- **JAL.** A=01, B=10, ResultSrc=00, PCWrite=1 (PC←target, ALUOut←OldPC+4). Next state is ALU_WB, which writes the link and retires.
- **JR.** A=10, B=01, ResultSrc=10, PCWrite=1, retire. Next state is FETCH.
- **Counter.** `instret` increments when retire=1 and wraps modulo 2^CNT_W.

## Timing
- **Reset.** rst_n low forces IDLE and instret=0 immediately, with no clock needed. All outputs are 0 while reset is asserted. After deassertion there is one IDLE cycle, then FETCH.
- **Reset mid-access.** Reset during any access abandons it. MemReq drops asynchronously; no partial retire is counted.
- **Cycle counts** with zero-wait memory, where every memory state lasts exactly one cycle:

  | Instruction | Cycles |
  |---|---|
  | R/I-ALU | 4 |
  | ld | 5 |
  | st | 4 |
  | beq/bne | 3 |
  | jal | 4 |
  | jr | 3 |

- **Wait states.** Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- **Memory handshake.**
  - MemReq, AdrSrc and MemWrite stay stable until the ready cycle.
  - mem_ready is ignored in non-memory states.
- **Single-cycle strobes.** PCWrite, IRWrite and RegWrite never assert for more than one cycle per state visit. retire pulses exactly once per instruction.

## Structure
- **Shared package `core_pkg`** holds:
  - opcode constants (OP_R, OP_I_MEM, OP_I_ALU, OP_ST, OP_BEQ, OP_BNE, OP_JAL, OP_JR);
  - 4-bit state encodings;
  - ALUOp, ResultSrc, ALUSrcA, ALUSrcB and ImmSrc select constants.
- **Sub-module `imm_src_decoder`** is a small combinational Op→ImmSrc block, reused by the single-cycle variant.
- **This module** contains the state register, next-state logic, output decode and the instret counter.

## Test plan
- **Reset then R-type.**
  - Stimulus: reset, then Op=000 with mem_ready held 1.
  - Expected: IDLE, FETCH, DECODE, EXEC_R, ALU_WB. RegWrite=1 only in cycle 5 with ResultSrc=00, and instret goes to 1.
- **ld with 2 wait states.**
  - Stimulus: Op=001, funct3=00, mem_ready=0 for two cycles in MEM_RD.
  - Expected: MemReq=1 and AdrSrc=1 for 3 cycles, then MEM_WB with ResultSrc=01; total 7 cycles.
- **bne not taken and taken.**
  - Stimulus: Op=101 with Zero=1, then Op=101 with Zero=0.
  - Expected: PCWrite=0 in BRANCH for the first, PCWrite=1 for the second; both retire after 3 cycles.
- **jal.**
  - Stimulus: Op=110.
  - Expected: PCWrite=1 with ResultSrc=00 in JAL, then RegWrite=1 in ALU_WB; retire asserts once.
- **Async reset in MEM_WR.**
  - Stimulus: rst_n pulled low mid-cycle while in MEM_WR with mem_ready=0.
  - Expected: MemReq and MemWrite drop before the next edge, state returns to IDLE, instret=0.
- **Counter wrap.**
  - Stimulus: CNT_W=4, 16 jr instructions.
  - Expected: instret returns to 0 after the 16th retire.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: opcode, FSM state and datapath select encodings shared by the core's control units.
package core_pkg;
  localparam logic [2:0] OP_R     = 3'b000;
  localparam logic [2:0] OP_I_MEM = 3'b001;
  localparam logic [2:0] OP_I_ALU = 3'b010;
  localparam logic [2:0] OP_ST    = 3'b011;
  localparam logic [2:0] OP_BEQ   = 3'b100;
  localparam logic [2:0] OP_BNE   = 3'b101;
  localparam logic [2:0] OP_JAL   = 3'b110;
  localparam logic [2:0] OP_JR    = 3'b111;
  localparam logic [1:0] F3_LD    = 2'b00;
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JR       = 4'd12
  } state_t;
  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_SUB     = 2'b01;
  localparam logic [1:0] ALU_FUNCT   = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;
  localparam logic [1:0] IMM_R       = 2'b00;
  localparam logic [1:0] IMM_I       = 2'b01;
  localparam logic [1:0] IMM_SB      = 2'b10;
  localparam logic [1:0] IMM_J       = 2'b11;
  function automatic logic is_ld(input logic [2:0] op, input logic [1:0] f3);
    return op == OP_I_MEM && f3 == F3_LD;
  endfunction
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: IR/ALU/memory inputs and datapath control outputs of the multicycle controller.
interface multicycle_controller_if #(parameter int CNT_W = 16);
  logic [2:0]       Op;
  logic [1:0]       funct3;
  logic             Zero;
  logic             mem_ready;
  logic             MemReq;
  logic             MemWrite;
  logic             AdrSrc;
  logic             IRWrite;
  logic             PCWrite;
  logic             RegWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       ImmSrc;
  logic             retire;
  logic [CNT_W-1:0] instret;
  modport master (
    input  Op, funct3, Zero, mem_ready,
    output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, retire, instret
  );
  modport slave (
    output Op, funct3, Zero, mem_ready,
    input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, retire, instret
  );
endinterface

// File: rtl/imm_src_decoder.sv
// imm_src_decoder: maps an opcode to its immediate format select.
module imm_src_decoder
  import core_pkg::*;
(
  input  logic [2:0] op_i,
  output logic [1:0] imm_src_o
);
  always_comb begin
    imm_src_o = (op_i == OP_I_MEM || op_i == OP_I_ALU)                  ? IMM_I  :
                (op_i == OP_ST || op_i == OP_BEQ || op_i == OP_BNE)     ? IMM_SB :
                (op_i == OP_JAL)                                        ? IMM_J  : IMM_R;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the shared datapath, with memory stall and retired-instruction counter.
module multicycle_controller
  import core_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multicycle_controller_if.master  bus
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic [1:0]       imm_dec;
  logic             mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retire;
  logic [1:0]       result_src, alu_src_a, alu_src_b, alu_op;
  imm_src_decoder u_imm (
    .op_i      (bus.Op),
    .imm_src_o (imm_dec)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + 1'b1;
    end
  end
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          result_src = RES_ALU;
          alu_src_b  = SRCB_FOUR;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        state_d   = (bus.Op == OP_R)                            ? S_EXEC_R   :
                    is_ld(bus.Op, bus.funct3)                   ? S_MEM_ADDR :
                    (bus.Op == OP_I_MEM || bus.Op == OP_I_ALU)  ? S_EXEC_I   :
                    (bus.Op == OP_ST)                           ? S_MEM_ADDR :
                    (bus.Op == OP_BEQ || bus.Op == OP_BNE)      ? S_BRANCH   :
                    (bus.Op == OP_JAL)                          ? S_JAL      : S_JR;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = is_ld(bus.Op, bus.funct3) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        state_d = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        result_src = RES_DATA;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        retire    = bus.mem_ready;
        state_d   = bus.mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_SUB;
        retire    = 1'b1;
        pc_write  = (bus.Op == OP_BEQ && bus.Zero) || (bus.Op == OP_BNE && !bus.Zero);
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        state_d   = S_ALU_WB;
      end
      S_JR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALU;
        pc_write   = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // IDLE (including reset) keeps every output low, so ImmSrc is masked there too.
  assign bus.ImmSrc    = (state_q == S_IDLE) ? IMM_R : imm_dec;
  assign bus.MemReq    = mem_req;
  assign bus.MemWrite  = mem_write;
  assign bus.AdrSrc    = adr_src;
  assign bus.IRWrite   = ir_write;
  assign bus.PCWrite   = pc_write;
  assign bus.RegWrite  = reg_write;
  assign bus.ResultSrc = result_src;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ALUOp     = alu_op;
  assign bus.retire    = retire;
  assign bus.instret   = instret_q;
endmodule
